// File: rtl/sr_pkg.sv
// Shared constants for the SR command sequencer: command codes, FSM
// state encoding and small helpers on command codes.
package sr_pkg;

  // Command codes driven towards the SR flip-flop.
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_CLR     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  // Arbitration FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Hold counter width; PULSE_LEN never exceeds 15.
  localparam int unsigned HOLD_W = 4;

  // True only for the two real commands; hold and the illegal code never count.
  function automatic logic sr_is_active(input logic [1:0] code);
    return (code != SR_HOLD) && (code != SR_ILLEGAL);
  endfunction

  // Flip-flop q after it samples the given command at a clock edge.
  function automatic logic sr_next_q(input logic q, input logic [1:0] code);
    logic nq;
    case (code)
      SR_SET:  nq = 1'b1;
      SR_CLR:  nq = 1'b0;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, stability counter that accepts
// a level change only after DEBOUNCE_CYCLES stable cycles, and rising-edge
// detection on the debounced level.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_evt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_deb;
  logic             r_deb_q;
  logic [CNT_W-1:0] r_cnt;

  // Two-stage synchroniser for the asynchronous raw request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only once the synchronised input has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb <= 1'b0;
      r_cnt <= CNT_ZERO;
    end else if (r_s2 == r_deb) begin
      r_cnt <= CNT_ZERO;
    end else if (r_cnt == CNT_LAST) begin
      r_deb <= r_s2;
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_q <= 1'b0;
    end else begin
      r_deb_q <= r_deb;
    end
  end

  // One-cycle event on each debounced rising edge; falling edges are ignored.
  assign o_evt = r_deb & ~r_deb_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Conditions raw set/clear requests into clean SR commands. Each channel is
// debounced and edge-detected, then an arbitration FSM emits one command at
// a time (never 2'b11) with a guaranteed hold cycle between commands. Events
// that arrive while busy are kept in one-deep pending bits. A shadow of the
// downstream flip-flop's q is maintained alongside.
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_LEN       = 1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       clr_in,
  output logic [1:0] sr,
  output logic       cmd_valid,
  output logic       conflict,
  output logic       overrun,
  output logic       q_shadow
);

  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PULSE_LEN);

  logic              w_set_evt;
  logic              w_clr_evt;
  logic              w_req_set;
  logic              w_req_clr;
  logic              w_busy;

  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_pend_set;
  logic              r_pend_clr;
  logic [1:0]        r_sr;
  logic              r_cmd_valid;
  logic              r_conflict;
  logic              r_overrun;
  logic              r_q;

  logic [1:0]        w_state_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_pend_set_nxt;
  logic              w_pend_clr_nxt;
  logic [1:0]        w_sr_nxt;
  logic              w_conflict_nxt;
  logic              w_overrun_nxt;

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_set (
    .clk   (clk),
    .rst   (rst),
    .i_raw (set_in),
    .o_evt (w_set_evt)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .i_raw (clr_in),
    .o_evt (w_clr_evt)
  );

  assign w_req_set = w_set_evt | r_pend_set;
  assign w_req_clr = w_clr_evt | r_pend_clr;
  assign w_busy    = (r_state == ST_DRIVE) || (r_state == ST_GAP);

  // Arbitration: next state, next command, pending bookkeeping and status pulses.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_pend_set_nxt = r_pend_set;
    w_pend_clr_nxt = r_pend_clr;
    w_sr_nxt       = r_sr;
    w_conflict_nxt = 1'b0;
    w_overrun_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_hold_nxt = HOLD_ZERO;
        if (w_req_set && w_req_clr) begin
          // Simultaneous opposite requests cancel each other.
          w_conflict_nxt = 1'b1;
          w_pend_set_nxt = 1'b0;
          w_pend_clr_nxt = 1'b0;
          w_sr_nxt       = SR_HOLD;
        end else if (w_req_set) begin
          w_sr_nxt       = SR_SET;
          w_state_nxt    = ST_DRIVE;
          w_pend_set_nxt = 1'b0;
          w_hold_nxt     = HOLD_ONE;
        end else if (w_req_clr) begin
          w_sr_nxt       = SR_CLR;
          w_state_nxt    = ST_DRIVE;
          w_pend_clr_nxt = 1'b0;
          w_hold_nxt     = HOLD_ONE;
        end else begin
          w_sr_nxt       = SR_HOLD;
        end
      end
      ST_DRIVE: begin
        if (r_hold >= HOLD_LAST) begin
          w_sr_nxt    = SR_HOLD;
          w_state_nxt = ST_GAP;
          w_hold_nxt  = HOLD_ZERO;
        end else begin
          w_hold_nxt  = r_hold + HOLD_ONE;
        end
      end
      ST_GAP: begin
        // Single enforced hold cycle before the next command.
        w_sr_nxt    = SR_HOLD;
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = HOLD_ZERO;
      end
      default: begin
        w_sr_nxt    = SR_HOLD;
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = HOLD_ZERO;
      end
    endcase

    // While a command is in flight, remember one event per kind; a second one is dropped.
    if (w_busy) begin
      if (w_set_evt) begin
        if (r_pend_set) begin
          w_overrun_nxt  = 1'b1;
        end else begin
          w_pend_set_nxt = 1'b1;
        end
      end else begin
        w_pend_set_nxt = r_pend_set;
      end
      if (w_clr_evt) begin
        if (r_pend_clr) begin
          w_overrun_nxt  = 1'b1;
        end else begin
          w_pend_clr_nxt = 1'b1;
        end
      end else begin
        w_pend_clr_nxt = r_pend_clr;
      end
    end else begin
      w_overrun_nxt = 1'b0;
    end
  end

  // FSM state, hold counter and pending bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= HOLD_ZERO;
      r_pend_set <= 1'b0;
      r_pend_clr <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold     <= w_hold_nxt;
      r_pend_set <= w_pend_set_nxt;
      r_pend_clr <= w_pend_clr_nxt;
    end
  end

  // Registered command outputs and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr        <= SR_HOLD;
      r_cmd_valid <= 1'b0;
      r_conflict  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_cmd_valid <= sr_is_active(w_sr_nxt);
      r_conflict  <= w_conflict_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Shadow q follows the command the flip-flop samples at this same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= sr_next_q(r_q, r_sr);
    end
  end

  assign sr        = r_sr;
  assign cmd_valid = r_cmd_valid;
  assign conflict  = r_conflict;
  assign overrun   = r_overrun;
  assign q_shadow  = r_q;

endmodule
